// File: rtl/modbus_msg_buffer.sv
// Modbus message buffer: host-side byte FIFOs for TX and RX with frame-level
// commit semantics toward a UART bridge.
// Optional build macro: MODBUS_MSGBUF_ERR_DROP_EN (discard frames ended with error).
module modbus_msg_buffer #(
   parameter int DEPTH = 256,
   parameter int CW    = 16
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic [7:0]    host_tx_data,
   input  logic          host_tx_push,
   output logic          host_tx_ready,
   input  logic          host_tx_commit,
   output logic [7:0]    host_rx_data,
   output logic          host_rx_valid,
   input  logic          host_rx_pop,
   output logic [7:0]    ln_tx_data,
   output logic          ln_tx_valid,
   input  logic          ln_tx_ready,
   input  logic [7:0]    ln_rx_data,
   input  logic          ln_rx_valid,
   input  logic          ln_frame_start,
   input  logic          ln_frame_end,
   input  logic          ln_frame_err,
   input  logic [15:0]   cfg_msg_wm,
   input  logic          cfg_flush,
   input  logic [2:0]    irq_w1c,
   output logic [CW-1:0] rx_count,
   output logic [CW-1:0] tx_count,
   output logic [15:0]   err_count,
   output logic [2:0]    irq,
   output logic [1:0]    stat
);
   localparam int AW = $clog2(DEPTH);

   typedef enum logic {TX_IDLE, TX_SEND} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_RECV, RX_DROP} rx_state_t;

   logic [7:0] tx_mem [DEPTH];
   logic [7:0] rx_mem [DEPTH];

   tx_state_t tx_state_q, tx_state_d;
   logic [AW-1:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [CW-1:0] tx_count_q, tx_count_d, tx_rem_q, tx_rem_d;
   logic tx_valid_q, tx_valid_d;
   logic tx_push, tx_pop, tx_done_set, tx_busy_set;

   rx_state_t rx_state_q, rx_state_d;
   logic [AW-1:0] rx_wr_q, rx_wr_d, rx_cptr_q, rx_cptr_d, rx_rd_q, rx_rd_d;
   logic [CW-1:0] rx_count_q, rx_count_d, rx_pend_q, rx_pend_d, rx_commit_add;
   logic rx_pop, rx_full, rx_wr_en, frame_set, ovf_set, err_inc;

   logic tx_done_q, tx_done_d, frame_q, frame_d, rx_ovf_q, rx_ovf_d, tx_busy_q, tx_busy_d;
   logic [15:0] err_count_q, err_count_d;
   logic wm_hit, w1c_unused;

   // TX side: FIFO bookkeeping plus the IDLE/SEND frame sender
   always_comb begin
      tx_state_d  = tx_state_q;
      tx_valid_d  = tx_valid_q;
      tx_rem_d    = tx_rem_q;
      tx_done_set = 1'b0;
      tx_busy_set = 1'b0;
      tx_push     = host_tx_push && (tx_count_q != CW'(DEPTH));
      tx_pop      = tx_valid_q && ln_tx_ready;
      tx_wr_d     = tx_push ? tx_wr_q + 1'b1 : tx_wr_q;
      tx_rd_d     = tx_pop ? tx_rd_q + 1'b1 : tx_rd_q;
      tx_count_d  = tx_count_q + CW'(tx_push) - CW'(tx_pop);
      case (tx_state_q)
         TX_IDLE: begin
            // Remaining is the fill level before any same-cycle push
            if (host_tx_commit && (tx_count_q != '0)) begin
               tx_state_d = TX_SEND;
               tx_valid_d = 1'b1;
               tx_rem_d   = tx_count_q;
            end
         end
         TX_SEND: begin
            if (host_tx_commit) tx_busy_set = 1'b1;
            if (tx_pop) begin
               tx_rem_d = tx_rem_q - 1'b1;
               if (tx_rem_q == CW'(1)) begin
                  tx_state_d  = TX_IDLE;
                  tx_valid_d  = 1'b0;
                  tx_done_set = 1'b1;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      if (cfg_flush) begin
         tx_state_d  = TX_IDLE;
         tx_valid_d  = 1'b0;
         tx_rem_d    = '0;
         tx_wr_d     = '0;
         tx_rd_d     = '0;
         tx_count_d  = '0;
         tx_done_set = 1'b0;
         tx_busy_set = 1'b0;
      end
   end

   // RX side: speculative frame writes that become visible only on a good frame end
   always_comb begin
      rx_state_d    = rx_state_q;
      rx_wr_d       = rx_wr_q;
      rx_cptr_d     = rx_cptr_q;
      rx_pend_d     = rx_pend_q;
      rx_commit_add = '0;
      rx_wr_en      = 1'b0;
      frame_set     = 1'b0;
      ovf_set       = 1'b0;
      err_inc       = 1'b0;
      rx_pop        = host_rx_pop && (rx_count_q != '0);
      rx_full       = (rx_count_q + rx_pend_q) == CW'(DEPTH);
      rx_rd_d       = rx_pop ? rx_rd_q + 1'b1 : rx_rd_q;
      case (rx_state_q)
         RX_RECV: begin
            if (ln_rx_valid) begin
               if (rx_full) begin
                  rx_state_d = ln_frame_end ? RX_IDLE : RX_DROP;
                  rx_wr_d    = rx_cptr_q;
                  rx_pend_d  = '0;
                  ovf_set    = 1'b1;
                  err_inc    = 1'b1;
               end else begin
                  rx_wr_en  = 1'b1;
                  rx_wr_d   = rx_wr_q + 1'b1;
                  rx_pend_d = rx_pend_q + 1'b1;
               end
            end
            // A byte arriving with frame_end has already been folded in above
            if (ln_frame_end && (rx_state_d == RX_RECV)) begin
               rx_state_d = RX_IDLE;
               err_inc    = ln_frame_err;
`ifdef MODBUS_MSGBUF_ERR_DROP_EN
               if (ln_frame_err) begin
                  rx_wr_d   = rx_cptr_q;
                  rx_pend_d = '0;
               end else begin
                  rx_cptr_d     = rx_wr_d;
                  rx_commit_add = rx_pend_d;
                  rx_pend_d     = '0;
                  frame_set     = 1'b1;
               end
`else
               rx_cptr_d     = rx_wr_d;
               rx_commit_add = rx_pend_d;
               rx_pend_d     = '0;
               frame_set     = 1'b1;
`endif
            end
         end
         RX_DROP: if (ln_frame_end) rx_state_d = RX_IDLE;
         RX_IDLE: rx_state_d = RX_IDLE;
         default: rx_state_d = RX_IDLE;
      endcase
      // A new frame start abandons any partial frame; a same-cycle byte is not kept
      if (ln_frame_start) begin
         rx_state_d    = RX_RECV;
         rx_wr_d       = rx_cptr_q;
         rx_pend_d     = '0;
         rx_wr_en      = 1'b0;
         rx_commit_add = '0;
         frame_set     = 1'b0;
         ovf_set       = 1'b0;
         err_inc       = 1'b0;
      end
      rx_count_d = rx_count_q - CW'(rx_pop) + rx_commit_add;
      if (cfg_flush) begin
         rx_state_d = RX_IDLE;
         rx_wr_d    = '0;
         rx_cptr_d  = '0;
         rx_rd_d    = '0;
         rx_pend_d  = '0;
         rx_count_d = '0;
         rx_wr_en   = 1'b0;
         frame_set  = 1'b0;
         ovf_set    = 1'b0;
         err_inc    = 1'b0;
      end
   end

   // Sticky interrupt/status bits and the saturating error counter
   always_comb begin
      tx_done_d   = (tx_done_q & ~irq_w1c[2]) | tx_done_set;
      frame_d     = (frame_q & ~irq_w1c[1]) | frame_set;
      rx_ovf_d    = rx_ovf_q | ovf_set;
      tx_busy_d   = tx_busy_q | tx_busy_set;
      err_count_d = (err_inc && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1 : err_count_q;
   end

   // State registers
   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         tx_state_q  <= TX_IDLE;
         tx_valid_q  <= 1'b0;
         tx_rem_q    <= '0;
         tx_wr_q     <= '0;
         tx_rd_q     <= '0;
         tx_count_q  <= '0;
         rx_state_q  <= RX_IDLE;
         rx_wr_q     <= '0;
         rx_cptr_q   <= '0;
         rx_rd_q     <= '0;
         rx_pend_q   <= '0;
         rx_count_q  <= '0;
         tx_done_q   <= 1'b0;
         frame_q     <= 1'b0;
         rx_ovf_q    <= 1'b0;
         tx_busy_q   <= 1'b0;
         err_count_q <= '0;
      end else begin
         tx_state_q  <= tx_state_d;
         tx_valid_q  <= tx_valid_d;
         tx_rem_q    <= tx_rem_d;
         tx_wr_q     <= tx_wr_d;
         tx_rd_q     <= tx_rd_d;
         tx_count_q  <= tx_count_d;
         rx_state_q  <= rx_state_d;
         rx_wr_q     <= rx_wr_d;
         rx_cptr_q   <= rx_cptr_d;
         rx_rd_q     <= rx_rd_d;
         rx_pend_q   <= rx_pend_d;
         rx_count_q  <= rx_count_d;
         tx_done_q   <= tx_done_d;
         frame_q     <= frame_d;
         rx_ovf_q    <= rx_ovf_d;
         tx_busy_q   <= tx_busy_d;
         err_count_q <= err_count_d;
      end
   end

   // Byte storage; contents are don't-care until pointers make them visible
   always_ff @(posedge PCLK) begin
      if (tx_push) tx_mem[tx_wr_q] <= host_tx_data;
      if (rx_wr_en) rx_mem[rx_wr_q] <= ln_rx_data;
   end

   assign wm_hit        = (cfg_msg_wm != 16'd0) && (32'(rx_count_q) >= 32'(cfg_msg_wm));
   assign w1c_unused    = irq_w1c[0];
   assign host_tx_ready = (tx_count_q != CW'(DEPTH));
   assign ln_tx_valid   = tx_valid_q;
   assign ln_tx_data    = tx_valid_q ? tx_mem[tx_rd_q] : 8'h00;
   assign host_rx_valid = (rx_count_q != '0);
   assign host_rx_data  = host_rx_valid ? rx_mem[rx_rd_q] : 8'h00;
   assign rx_count      = rx_count_q;
   assign tx_count      = tx_count_q;
   assign err_count     = err_count_q;
   assign irq           = {tx_done_q, frame_q, wm_hit};
   assign stat          = {rx_ovf_q, tx_busy_q};
endmodule

// File: tb/tb_modbus_msg_buffer.sv
// Self-checking bench for modbus_msg_buffer (DEPTH = 16) against a queue-level model.
module tb_modbus_msg_buffer;
   localparam int DEPTH = 16;
   localparam int CW    = 8;
`ifdef MODBUS_MSGBUF_ERR_DROP_EN
   localparam bit DROP_EN = 1'b1;
`else
   localparam bit DROP_EN = 1'b0;
`endif

   logic PCLK = 1'b0;
   logic PRESETn;
   logic [7:0] host_tx_data, host_rx_data, ln_tx_data, ln_rx_data;
   logic host_tx_push, host_tx_ready, host_tx_commit, host_rx_valid, host_rx_pop;
   logic ln_tx_valid, ln_tx_ready, ln_rx_valid, ln_frame_start, ln_frame_end, ln_frame_err;
   logic [15:0] cfg_msg_wm, err_count;
   logic cfg_flush;
   logic [2:0] irq_w1c, irq;
   logic [CW-1:0] rx_count, tx_count;
   logic [1:0] stat;

   int n_checks = 0;
   int n_errors = 0;
   logic [7:0] tx_model[$];
   logic [7:0] rx_model[$];
   int err_exp = 0;
   bit ovf_exp = 0;
   bit frame_exp = 0;

   modbus_msg_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn),
      .host_tx_data(host_tx_data), .host_tx_push(host_tx_push), .host_tx_ready(host_tx_ready),
      .host_tx_commit(host_tx_commit),
      .host_rx_data(host_rx_data), .host_rx_valid(host_rx_valid), .host_rx_pop(host_rx_pop),
      .ln_tx_data(ln_tx_data), .ln_tx_valid(ln_tx_valid), .ln_tx_ready(ln_tx_ready),
      .ln_rx_data(ln_rx_data), .ln_rx_valid(ln_rx_valid), .ln_frame_start(ln_frame_start),
      .ln_frame_end(ln_frame_end), .ln_frame_err(ln_frame_err),
      .cfg_msg_wm(cfg_msg_wm), .cfg_flush(cfg_flush), .irq_w1c(irq_w1c),
      .rx_count(rx_count), .tx_count(tx_count), .err_count(err_count), .irq(irq), .stat(stat)
   );

   always #5 PCLK = ~PCLK;

   task automatic tick;
      @(posedge PCLK);
      #1;
   endtask

   task automatic clear_irq(input logic [2:0] mask);
      irq_w1c = mask;
      tick;
      irq_w1c = 3'b000;
   endtask

   // Drives one frame on the line side and advances the reference model
   task automatic rx_send_frame(input int len, input bit err, input bit end_last, input bit pop_end);
      logic [7:0] bytes[$];
      int space;
      space = DEPTH - rx_model.size();
      ln_frame_start = 1'b1;
      tick;
      ln_frame_start = 1'b0;
      for (int i = 0; i < len; i++) begin
         ln_rx_data  = 8'($urandom);
         ln_rx_valid = 1'b1;
         bytes.push_back(ln_rx_data);
         if (end_last && i == len - 1) begin
            ln_frame_end = 1'b1;
            ln_frame_err = err;
            host_rx_pop  = pop_end;
         end
         tick;
      end
      ln_rx_valid = 1'b0;
      host_rx_pop = 1'b0;
      if (!end_last) begin
         ln_frame_end = 1'b1;
         ln_frame_err = err;
         host_rx_pop  = pop_end;
         tick;
      end
      ln_frame_end = 1'b0;
      ln_frame_err = 1'b0;
      host_rx_pop  = 1'b0;
      if (pop_end && rx_model.size() > 0) void'(rx_model.pop_front());
      if (len > space) begin
         ovf_exp = 1'b1;
         err_exp++;
      end else begin
         if (err) err_exp++;
         if (!(err && DROP_EN)) begin
            foreach (bytes[i]) rx_model.push_back(bytes[i]);
            frame_exp = 1'b1;
         end
      end
   endtask

   task automatic test_reset;
      PRESETn = 1'b0;
      host_tx_data = 0; host_tx_push = 0; host_tx_commit = 0; host_rx_pop = 0;
      ln_tx_ready = 0; ln_rx_data = 0; ln_rx_valid = 0; ln_frame_start = 0;
      ln_frame_end = 0; ln_frame_err = 0; cfg_msg_wm = 0; cfg_flush = 0; irq_w1c = 0;
      tick; tick;
      n_checks++;
      if ({ln_tx_valid, host_rx_valid, host_tx_ready, irq, stat} !== 8'b0010_0000) begin
         n_errors++;
         $display("FAIL reset_flags: got %b expected 00100000", {ln_tx_valid, host_rx_valid, host_tx_ready, irq, stat});
      end
      n_checks++;
      if ({rx_count, tx_count, err_count, ln_tx_data, host_rx_data} !== '0) begin
         n_errors++;
         $display("FAIL reset_values: rx_count %0d tx_count %0d err %0d txd %0h rxd %0h expected all 0",
                  rx_count, tx_count, err_count, ln_tx_data, host_rx_data);
      end
      PRESETn = 1'b1;
      tick;
   endtask

   task automatic test_tx_fixed;
      logic [7:0] e;
      for (int i = 1; i <= 8; i++) begin
         host_tx_data = 8'(i); host_tx_push = 1'b1; tx_model.push_back(8'(i));
         tick;
      end
      host_tx_push = 1'b0;
      n_checks++;
      if (tx_count !== CW'(8)) begin n_errors++; $display("FAIL txfix_count: got %0d expected 8", tx_count); end
      ln_tx_ready = 1'b1; host_tx_commit = 1'b1;
      tick;
      host_tx_commit = 1'b0;
      for (int i = 0; i < 8; i++) begin
         e = tx_model.pop_front();
         n_checks++;
         if (ln_tx_valid !== 1'b1 || ln_tx_data !== e) begin
            n_errors++;
            $display("FAIL txfix_byte%0d: got valid %b data %0h expected valid 1 data %0h", i, ln_tx_valid, ln_tx_data, e);
         end
         tick;
      end
      n_checks++;
      if ({ln_tx_valid, irq[2], tx_count} !== {1'b0, 1'b1, CW'(0)}) begin
         n_errors++;
         $display("FAIL txfix_done: got valid %b irq2 %b count %0d expected 0 1 0", ln_tx_valid, irq[2], tx_count);
      end
      ln_tx_ready = 1'b0;
      clear_irq(3'b100);
      n_checks++;
      if (irq[2] !== 1'b0) begin n_errors++; $display("FAIL txfix_w1c: got %b expected 0", irq[2]); end
      $display("tx_fixed: 8 bytes sent");
   endtask

   task automatic test_tx_random;
      int n, got, cyc;
      logic [7:0] e;
      for (int rep = 0; rep < 3; rep++) begin
         n = $urandom_range(3, DEPTH);
         for (int i = 0; i < n; i++) begin
            host_tx_data = 8'($urandom); host_tx_push = 1'b1; tx_model.push_back(host_tx_data);
            tick;
         end
         host_tx_push = 1'b0;
         host_tx_commit = 1'b1;
         tick;
         host_tx_commit = 1'b0;
         got = 0; cyc = 0;
         while (got < n && cyc < 40 * n) begin
            ln_tx_ready = 1'($urandom_range(0, 1));
            if (ln_tx_valid && ln_tx_ready) begin
               e = tx_model.pop_front();
               n_checks++;
               if (ln_tx_data !== e) begin
                  n_errors++;
                  $display("FAIL txrand_byte%0d: got %0h expected %0h", got, ln_tx_data, e);
               end
               got++;
            end
            tick;
            cyc++;
         end
         ln_tx_ready = 1'b0;
         n_checks++;
         if (got != n || ln_tx_valid !== 1'b0 || irq[2] !== 1'b1 || tx_count !== CW'(0)) begin
            n_errors++;
            $display("FAIL txrand_end: got %0d bytes valid %b irq2 %b count %0d expected %0d bytes 0 1 0",
                     got, ln_tx_valid, irq[2], tx_count, n);
         end
         tx_model.delete();
         clear_irq(3'b100);
         $display("tx_random: frame of %0d bytes", n);
      end
   endtask

   task automatic test_tx_busy_flush;
      logic [7:0] e;
      for (int i = 0; i < 4; i++) begin
         host_tx_data = 8'($urandom); host_tx_push = 1'b1; tx_model.push_back(host_tx_data);
         tick;
      end
      host_tx_push = 1'b0;
      host_tx_commit = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
         host_tx_data = 8'($urandom); host_tx_push = 1'b1; tx_model.push_back(host_tx_data);
         tick;
         host_tx_commit = 1'b0;
      end
      host_tx_push = 1'b0;
      n_checks++;
      if (stat[0] !== 1'b1 || tx_count !== CW'(7) || ln_tx_valid !== 1'b1) begin
         n_errors++;
         $display("FAIL busy_stat: got stat0 %b count %0d valid %b expected 1 7 1", stat[0], tx_count, ln_tx_valid);
      end
      ln_tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         e = tx_model.pop_front();
         n_checks++;
         if (ln_tx_valid !== 1'b1 || ln_tx_data !== e) begin
            n_errors++;
            $display("FAIL busy_byte%0d: got %b/%0h expected 1/%0h", i, ln_tx_valid, ln_tx_data, e);
         end
         tick;
      end
      n_checks++;
      if (ln_tx_valid !== 1'b0 || tx_count !== CW'(3)) begin
         n_errors++;
         $display("FAIL busy_frame_len: got valid %b count %0d expected 0 3", ln_tx_valid, tx_count);
      end
      clear_irq(3'b100);
      host_tx_commit = 1'b1;
      tick;
      host_tx_commit = 1'b0;
      for (int i = 0; i < 3; i++) begin
         e = tx_model.pop_front();
         n_checks++;
         if (ln_tx_valid !== 1'b1 || ln_tx_data !== e) begin
            n_errors++;
            $display("FAIL busy_second%0d: got %b/%0h expected 1/%0h", i, ln_tx_valid, ln_tx_data, e);
         end
         tick;
      end
      clear_irq(3'b100);
      for (int i = 0; i < 5; i++) begin
         host_tx_data = 8'($urandom); host_tx_push = 1'b1;
         tick;
      end
      host_tx_push = 1'b0;
      host_tx_commit = 1'b1;
      tick;
      host_tx_commit = 1'b0;
      tick; tick;
      cfg_flush = 1'b1;
      tick;
      cfg_flush = 1'b0;
      n_checks++;
      if (ln_tx_valid !== 1'b0 || tx_count !== CW'(0) || stat[0] !== 1'b1 || host_tx_ready !== 1'b1) begin
         n_errors++;
         $display("FAIL flush_tx: got valid %b count %0d stat0 %b ready %b expected 0 0 1 1",
                  ln_tx_valid, tx_count, stat[0], host_tx_ready);
      end
      host_tx_commit = 1'b1;
      tick;
      host_tx_commit = 1'b0;
      tick;
      n_checks++;
      if (ln_tx_valid !== 1'b0 || irq[2] !== 1'b0) begin
         n_errors++;
         $display("FAIL empty_commit: got valid %b irq2 %b expected 0 0", ln_tx_valid, irq[2]);
      end
      ln_tx_ready = 1'b0;
      $display("tx_busy_flush: busy commit and flush done");
   endtask

   task automatic test_back_to_back;
      logic [7:0] e;
      for (int i = 0; i < DEPTH + 3; i++) begin
         host_tx_data = 8'($urandom); host_tx_push = 1'b1;
         if (i < DEPTH) tx_model.push_back(host_tx_data);
         tick;
      end
      host_tx_push = 1'b0;
      n_checks++;
      if (tx_count !== CW'(DEPTH) || host_tx_ready !== 1'b0) begin
         n_errors++;
         $display("FAIL tx_full: got count %0d ready %b expected %0d 0", tx_count, host_tx_ready, DEPTH);
      end
      host_tx_commit = 1'b1;
      tick;
      host_tx_commit = 1'b0;
      ln_tx_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         e = tx_model.pop_front();
         // Refill while draining: each cycle pushes one byte and pops one
         host_tx_data = 8'($urandom); host_tx_push = (i >= 1);
         if (i >= 1) tx_model.push_back(host_tx_data);
         n_checks++;
         if (ln_tx_valid !== 1'b1 || ln_tx_data !== e) begin
            n_errors++;
            $display("FAIL b2b_byte%0d: got %b/%0h expected 1/%0h", i, ln_tx_valid, ln_tx_data, e);
         end
         tick;
         if (i >= 1 && i < DEPTH - 1) begin
            n_checks++;
            if (tx_count !== CW'(DEPTH - 1)) begin
               n_errors++;
               $display("FAIL b2b_count%0d: got %0d expected %0d", i, tx_count, DEPTH - 1);
            end
         end
      end
      host_tx_push = 1'b0;
      n_checks++;
      if (ln_tx_valid !== 1'b0 || tx_count !== CW'(tx_model.size()) || irq[2] !== 1'b1) begin
         n_errors++;
         $display("FAIL b2b_end: got valid %b count %0d irq2 %b expected 0 %0d 1",
                  ln_tx_valid, tx_count, irq[2], tx_model.size());
      end
      clear_irq(3'b100);
      cfg_flush = 1'b1;
      tick;
      cfg_flush = 1'b0;
      tx_model.delete();
      ln_tx_ready = 1'b0;
      $display("back_to_back: full FIFO drained with concurrent refill");
   endtask

   task automatic test_rx_basic;
      cfg_msg_wm = 16'd4;
      rx_send_frame(6, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (host_rx_valid !== 1'b1 || rx_count !== CW'(6) || irq !== 3'b011) begin
         n_errors++;
         $display("FAIL rxbasic_commit: got valid %b count %0d irq %b expected 1 6 011", host_rx_valid, rx_count, irq);
      end
      for (int i = 0; i < 6; i++) begin
         n_checks++;
         if (host_rx_valid !== 1'b1 || host_rx_data !== rx_model[0]) begin
            n_errors++;
            $display("FAIL rxbasic_byte%0d: got %b/%0h expected 1/%0h", i, host_rx_valid, host_rx_data, rx_model[0]);
         end
         void'(rx_model.pop_front());
         host_rx_pop = 1'b1;
         tick;
      end
      host_rx_pop = 1'b0;
      n_checks++;
      if (rx_count !== CW'(0) || irq[0] !== 1'b0 || host_rx_valid !== 1'b0) begin
         n_errors++;
         $display("FAIL rxbasic_drained: got count %0d wm %b valid %b expected 0 0 0", rx_count, irq[0], host_rx_valid);
      end
      host_rx_pop = 1'b1;
      tick;
      host_rx_pop = 1'b0;
      n_checks++;
      if (rx_count !== CW'(0)) begin n_errors++; $display("FAIL rx_empty_pop: got %0d expected 0", rx_count); end
      clear_irq(3'b010);
      frame_exp = 1'b0;
      $display("rx_basic: 6-byte frame committed and read");
   endtask

   task automatic test_rx_overflow;
      rx_send_frame(20, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if (rx_count !== CW'(0) || stat[1] !== 1'b1 || err_count !== 16'(err_exp) || irq[1] !== 1'b0) begin
         n_errors++;
         $display("FAIL rx_ovf: got count %0d stat1 %b err %0d irq1 %b expected 0 1 %0d 0",
                  rx_count, stat[1], err_count, irq[1], err_exp);
      end
      rx_send_frame(4, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (rx_count !== CW'(4) || irq[1] !== 1'b1) begin
         n_errors++;
         $display("FAIL rx_after_ovf: got count %0d irq1 %b expected 4 1", rx_count, irq[1]);
      end
      rx_send_frame(5, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (rx_count !== CW'(rx_model.size()) || err_count !== 16'(err_exp)) begin
         n_errors++;
         $display("FAIL rx_err_frame: got count %0d err %0d expected %0d %0d",
                  rx_count, err_count, rx_model.size(), err_exp);
      end
      clear_irq(3'b010);
      frame_exp = 1'b0;
      $display("rx_overflow: overflow, recovery and error frame done");
   endtask

   task automatic test_rx_rewind;
      int base;
      base = rx_model.size();
      ln_rx_valid = 1'b1;
      repeat (3) begin ln_rx_data = 8'($urandom); tick; end
      ln_frame_start = 1'b1; ln_rx_valid = 1'b0;
      tick;
      ln_frame_start = 1'b0; ln_rx_valid = 1'b1;
      repeat (3) begin ln_rx_data = 8'($urandom); tick; end
      ln_rx_valid = 1'b0;
      n_checks++;
      if (rx_count !== CW'(base)) begin
         n_errors++;
         $display("FAIL rx_uncommitted: got %0d expected %0d", rx_count, base);
      end
      rx_send_frame(2, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (rx_count !== CW'(rx_model.size())) begin
         n_errors++;
         $display("FAIL rx_rewind: got %0d expected %0d", rx_count, rx_model.size());
      end
      $display("rx_rewind: partial frame replaced");
   endtask

   task automatic test_rx_random;
      int len, k;
      bit err, last, pe;
      for (int it = 0; it < 10; it++) begin
         cfg_msg_wm = 16'($urandom_range(0, 6));
         len = $urandom_range(1, 14);
         err = ($urandom_range(0, 3) == 0);
         last = 1'($urandom_range(0, 1));
         pe = 1'($urandom_range(0, 1));
         rx_send_frame(len, err, last, pe);
         n_checks++;
         if (rx_count !== CW'(rx_model.size()) || err_count !== 16'(err_exp) || stat[1] !== ovf_exp ||
             irq[1] !== frame_exp || host_rx_valid !== (rx_model.size() != 0) ||
             irq[0] !== (cfg_msg_wm != 0 && rx_model.size() >= int'(cfg_msg_wm))) begin
            n_errors++;
            $display("FAIL rxrand_frame%0d: got count %0d err %0d stat1 %b irq %b expected count %0d err %0d stat1 %b irq1 %b wm %0d",
                     it, rx_count, err_count, stat[1], irq, rx_model.size(), err_exp, ovf_exp, frame_exp, cfg_msg_wm);
         end
         clear_irq(3'b010);
         frame_exp = 1'b0;
         k = $urandom_range(0, rx_model.size());
         for (int i = 0; i < k; i++) begin
            n_checks++;
            if (host_rx_valid !== 1'b1 || host_rx_data !== rx_model[0]) begin
               n_errors++;
               $display("FAIL rxrand_pop%0d: got %b/%0h expected 1/%0h", i, host_rx_valid, host_rx_data, rx_model[0]);
            end
            void'(rx_model.pop_front());
            host_rx_pop = 1'b1;
            tick;
         end
         host_rx_pop = 1'b0;
         $display("rx_random: frame %0d len %0d err %0b popped %0d left %0d", it, len, err, k, rx_model.size());
      end
   endtask

   task automatic test_flush_and_reset;
      rx_send_frame(3, 1'b0, 1'b1, 1'b0);
      cfg_flush = 1'b1;
      tick;
      cfg_flush = 1'b0;
      rx_model.delete();
      n_checks++;
      if (rx_count !== CW'(0) || host_rx_valid !== 1'b0 || err_count !== 16'(err_exp) || stat[1] !== ovf_exp) begin
         n_errors++;
         $display("FAIL flush_rx: got count %0d valid %b err %0d stat1 %b expected 0 0 %0d %b",
                  rx_count, host_rx_valid, err_count, stat[1], err_exp, ovf_exp);
      end
      clear_irq(3'b010);
      for (int i = 0; i < 3; i++) begin
         host_tx_data = 8'($urandom); host_tx_push = 1'b1;
         tick;
      end
      host_tx_push = 1'b0; host_tx_commit = 1'b1;
      tick;
      host_tx_commit = 1'b0;
      ln_frame_start = 1'b1;
      tick;
      ln_frame_start = 1'b0;
      PRESETn = 1'b0;
      #2;
      PRESETn = 1'b1;
      ln_tx_ready = 1'b1;
      ln_frame_end = 1'b1;
      tick;
      ln_frame_end = 1'b0;
      tick; tick;
      n_checks++;
      if ({ln_tx_valid, tx_count, rx_count, err_count, stat, irq} !== '0) begin
         n_errors++;
         $display("FAIL reset_mid: got valid %b tx %0d rx %0d err %0d stat %b irq %b expected all 0",
                  ln_tx_valid, tx_count, rx_count, err_count, stat, irq);
      end
      ln_tx_ready = 1'b0;
      $display("flush_and_reset: state cleared");
   endtask

   initial begin
      test_reset;
      test_tx_fixed;
      test_tx_random;
      test_tx_busy_flush;
      test_back_to_back;
      test_rx_basic;
      test_rx_overflow;
      test_rx_rewind;
      test_rx_random;
      test_flush_and_reset;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/modbus_msg_buffer.md
MODBUS_MSG_BUFFER -- requirements
Module: modbus_msg_buffer

Interface
REQ-001 Parameter DEPTH, default 256: bytes per direction FIFO; power of two, 16..4096.
REQ-002 Parameter CW, default 16: width of count/status outputs; CW SHALL be at least log2(DEPTH)+1.
REQ-003 PCLK  in  1  sole clock; all logic on rising edge.
REQ-004 PRESETn  in  1  reset, asynchronous assert, active-low.
REQ-005 host_tx_data in 8, host_tx_push in 1, host_tx_ready out 1: host byte write into TX FIFO.
REQ-006 host_tx_commit  in  1  pulse; requests transmission of all bytes currently in TX FIFO.
REQ-007 host_rx_data out 8, host_rx_valid out 1, host_rx_pop in 1: host byte read, first-word fall-through.
REQ-008 ln_tx_data out 8, ln_tx_valid out 1, ln_tx_ready in 1: byte stream to UART bridge.
REQ-009 ln_rx_data in 8, ln_rx_valid in 1, ln_frame_start in 1, ln_frame_end in 1, ln_frame_err in 1: framed bytes from UART bridge; err qualifies frame_end.
REQ-010 cfg_msg_wm in 16 (RX watermark, 0 = off), cfg_flush in 1 (pulse), irq_w1c in 3 (clear mask).
REQ-011 rx_count out CW, tx_count out CW, err_count out 16, irq out 3 {tx_done, frame, wm}, stat out 2 {rx_ovf, tx_busy_err}.

Function
REQ-012 TX push accepted when host_tx_push && host_tx_ready; host_tx_ready = (tx_count != DEPTH); push when full is dropped, no pointer change.
REQ-013 TX FSM states IDLE, SEND; IDLE -> SEND on host_tx_commit with tx_count != 0, latching remaining = tx_count; commit with tx_count = 0 ignored.
REQ-014 ln_tx_valid SHALL assert the cycle after the accepted commit, remain high in SEND, data stable until ln_tx_valid && ln_tx_ready.
REQ-015 Each line handshake pops one byte, decrements remaining; handshake with remaining = 1 -> IDLE, sets irq[2].
REQ-016 Pushes during SEND accepted into FIFO behind the frame but not sent until the next commit; commit during SEND ignored and sets stat[0] sticky.
REQ-017 Simultaneous push and line pop: tx_count unchanged.
REQ-018 RX FSM states IDLE, RECV, DROP; bytes arriving in IDLE are discarded.
REQ-019 ln_frame_start (any state) -> RECV; checkpoint = committed write pointer; uncommitted bytes of a prior partial frame are rewound.
REQ-020 In RECV, each ln_rx_valid writes one byte; a write with FIFO full -> DROP, write pointer rewound to checkpoint, stat[1] set sticky.
REQ-021 DROP -> IDLE on ln_frame_end; no commit.
REQ-022 RECV + ln_frame_end, good frame: committed pointer = write pointer, irq[1] set, -> IDLE; ln_rx_valid in the same cycle is written first and included.
REQ-023 Only committed bytes visible: host_rx_valid = (rx_count != 0), rx_count counts committed unread bytes; host_rx_valid rises the cycle after the committing frame_end.
REQ-024 host_rx_pop with host_rx_valid low is ignored; pop and commit in same cycle both take effect.
REQ-025 irq[0] level = (cfg_msg_wm != 0) && (rx_count >= cfg_msg_wm); irq[2:1] sticky, cleared by irq_w1c bit; set wins over same-cycle clear.
REQ-026 err_count increments (saturating at 0xFFFF) on each frame_end in RECV with ln_frame_err = 1, and on each entry to DROP.
REQ-027 Pointers wrap modulo DEPTH; counts are full CW-bit, no wrap.
REQ-028 cfg_flush: both FIFOs emptied, both FSMs IDLE, remaining = 0 in the next cycle; irq, stat, err_count preserved; flush overrides all same-cycle events.

Reset
REQ-029 PRESETn low: FIFOs empty, FSMs IDLE, irq = 0, stat = 0, err_count = 0, rx_count = tx_count = 0, ln_tx_valid = 0, host_rx_valid = 0, host_tx_ready = 1, data outputs 0.
REQ-030 Reset mid-frame or mid-SEND abandons the frame with no further line handshakes; FIFO storage contents need not be cleared.

Configuration
REQ-031 Macro MODBUS_MSGBUF_ERR_DROP_EN defined: frame_end with ln_frame_err = 1 rewinds to checkpoint, no commit, no irq[1].
REQ-032 Macro undefined: ln_frame_err frames commit as good frames; err_count still increments.

Verification
REQ-033 Push 8 bytes 01..08, commit, ln_tx_ready = 1 -> ln_tx_valid next cycle, 8 bytes in order over 8 cycles, irq[2] = 1, tx_count = 0.
REQ-034 Frame start, 6 bytes, frame_end err = 0, cfg_msg_wm = 4 -> host_rx_valid next cycle, rx_count = 6, irq = 3'b011; pop 6 -> rx_count = 0, irq[0] = 0.
REQ-035 DEPTH = 16, frame of 20 bytes -> DROP, rx_count = 0, stat[1] = 1, err_count = 1; next 4-byte frame commits normally.
REQ-036 frame_end with err = 1 -> with macro rx_count = 0, err_count = 1; without macro rx_count = frame length, err_count = 1.
REQ-037 Commit during SEND -> stat[0] = 1, current frame unaffected; cfg_flush mid-SEND -> ln_tx_valid = 0 next cycle, tx_count = 0.
